// File: rtl/traffic_pkg.sv
// Shared light codes, fault codes and monitor states for the traffic signal path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package traffic_pkg;

   // Light codes on the 2-bit signal bus, shared with the controller
   localparam logic [1:0] RED     = 2'b00;
   localparam logic [1:0] YELLOW  = 2'b01;
   localparam logic [1:0] GREEN   = 2'b10;
   localparam logic [1:0] ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      FLT_NONE    = 3'd0,
      FLT_ILLEGAL = 3'd1,
      FLT_ORDER   = 3'd2,
      FLT_SHORT   = 3'd3,
      FLT_LONG    = 3'd4
   } fault_code_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      T_RED  = 3'd1,
      T_YEL  = 3'd2,
      T_GRN  = 3'd3,
      RESYNC = 3'd4
   } mon_state_t;

   // Code that legally follows the given code; ILLEGAL has no successor
   function automatic logic [1:0] next_code(input logic [1:0] cur);
      case (cur)
         RED:     next_code = YELLOW;
         YELLOW:  next_code = GREEN;
         GREEN:   next_code = RED;
         default: next_code = ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/traffic_signal_monitor_if.sv
// Bus between the traffic controller side and the signal monitor.
// Latency: none (wiring only).
// Backpressure: none; the monitor is a passive observer.
interface traffic_signal_monitor_if;

   logic [1:0] signal;
   logic       fault_clr;
   logic       phase_done;
   logic [3:0] phase_len;
   logic [7:0] cycle_cnt;
   logic       fault;
   logic [2:0] fault_code;

   // Controller / consumer side drives the light code and the clear pulse
   modport master (
      output signal, fault_clr,
      input  phase_done, phase_len, cycle_cnt, fault, fault_code
   );

   // Monitor side observes the light code and reports status
   modport slave (
      input  signal, fault_clr,
      output phase_done, phase_len, cycle_cnt, fault, fault_code
   );

endinterface

// File: rtl/traffic_signal_monitor_phase_timer.sv
// Saturating 4-bit dwell counter with a per-phase maximum compare.
// Latency: count updates one cycle after restart/hold are sampled.
// Backpressure: none; hold freezes the count.
module phase_timer #(
   parameter int MAX_RG  = 10,
   parameter int MAX_YEL = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       restart,
   input  logic       hold,
   input  logic       yel_sel,
   output logic [3:0] count,
   output logic       at_max
);

   logic [3:0] max_sel;

   assign max_sel = yel_sel ? 4'(MAX_YEL) : 4'(MAX_RG);
   assign at_max  = (count == max_sel);

   // Dwell counter: restart loads 1 (the sample that opened the phase), else count up to 15
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 4'd0;
      end else if (restart) begin
         count <= 4'd1;
      end else if (!hold && count != 4'hF) begin
         count <= count + 4'd1;
      end
   end

endmodule

// File: rtl/traffic_signal_monitor.sv
// Passive checker of light phase order and dwell windows, with sticky first-fault latch.
// Latency: every output registered, one cycle after the sampling posedge.
// Backpressure: none; observes the signal bus every cycle and never stalls it.
module traffic_signal_monitor
   import traffic_pkg::*;
#(
   parameter int MIN_RG  = 6,
   parameter int MAX_RG  = 10,
   parameter int MIN_YEL = 1,
   parameter int MAX_YEL = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   traffic_signal_monitor_if.slave bus
);

   if (!(MIN_RG >= 1 && MIN_RG <= MAX_RG && MAX_RG <= 14 &&
         MIN_YEL >= 1 && MIN_YEL <= MAX_YEL && MAX_YEL <= 14)) begin : g_bad_params
      $error("traffic_signal_monitor: need 1 <= MIN <= MAX <= 14");
   end

   mon_state_t  state;
   logic [1:0]  prev_sig;
   logic        phase_done_r;
   logic [3:0]  phase_len_r;
   logic [7:0]  cycle_cnt_r;
   logic        fault_r;
   fault_code_t fault_code_r;

   logic [3:0]  count;
   logic        at_max;
   logic        restart;
   logic        hold;

   logic [1:0]  cur_code;
   logic        in_phase;
   logic        same;
   logic        adv;
   logic        min_ok;
   logic        enter_red;
   mon_state_t  adv_state;
   fault_code_t det_code;

   phase_timer #(
      .MAX_RG  (MAX_RG),
      .MAX_YEL (MAX_YEL)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .hold    (hold),
      .yel_sel (state == T_YEL),
      .count   (count),
      .at_max  (at_max)
   );

   // Classify the current sample against the phase being tracked
   always_comb begin
      cur_code  = RED;
      adv_state = T_YEL;
      in_phase  = 1'b0;
      case (state)
         T_RED: begin cur_code = RED;    adv_state = T_YEL; in_phase = 1'b1; end
         T_YEL: begin cur_code = YELLOW; adv_state = T_GRN; in_phase = 1'b1; end
         T_GRN: begin cur_code = GREEN;  adv_state = T_RED; in_phase = 1'b1; end
         default: ;
      endcase

      same   = in_phase && (bus.signal == cur_code);
      adv    = in_phase && (bus.signal == next_code(cur_code));
      min_ok = (state == T_YEL) ? (count >= 4'(MIN_YEL)) : (count >= 4'(MIN_RG));

      // A RED held steady through a fault must not resync; only a fresh RED edge does
      enter_red = (bus.signal == RED) &&
                  ((state == IDLE) || (state == RESYNC && prev_sig != RED));

      // Illegal code outranks every other check in the same cycle
      det_code = FLT_NONE;
      if (bus.signal == ILLEGAL) begin
         det_code = FLT_ILLEGAL;
      end else if (same && at_max) begin
         det_code = FLT_LONG;
      end else if (adv && !min_ok) begin
         det_code = FLT_SHORT;
      end else if (in_phase && !same && !adv) begin
         det_code = FLT_ORDER;
      end

      restart = enter_red || (adv && min_ok);
      hold    = !(same && !at_max);
   end

   // Phase FSM with registered reporting outputs, cycle counter and sticky fault latch
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         prev_sig     <= RED;
         phase_done_r <= 1'b0;
         phase_len_r  <= 4'd0;
         cycle_cnt_r  <= 8'd0;
         fault_r      <= 1'b0;
         fault_code_r <= FLT_NONE;
      end else begin
         prev_sig     <= bus.signal;
         phase_done_r <= 1'b0;

         if (det_code != FLT_NONE) begin
            state <= RESYNC;
         end else if (enter_red) begin
            state <= T_RED;
         end else if (adv) begin
            state        <= adv_state;
            phase_done_r <= 1'b1;
            phase_len_r  <= count;
            if (state == T_GRN) begin
               cycle_cnt_r <= cycle_cnt_r + 8'd1;
            end
         end

         // First fault sticks; a fault arriving with the clear replaces the old one
         if (det_code != FLT_NONE) begin
            if (!fault_r || bus.fault_clr) begin
               fault_r      <= 1'b1;
               fault_code_r <= det_code;
            end
         end else if (bus.fault_clr) begin
            fault_r      <= 1'b0;
            fault_code_r <= FLT_NONE;
         end
      end
   end

   assign bus.phase_done = phase_done_r;
   assign bus.phase_len  = phase_len_r;
   assign bus.cycle_cnt  = cycle_cnt_r;
   assign bus.fault      = fault_r;
   assign bus.fault_code = fault_code_r;

endmodule
